// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop synchronizer, per-key stability counter,
// registered press/release pulses and a sticky pressed-since-clear flag.
module key_debounce #(
    parameter int NUM_KEYS = 2,
    parameter int CNT_MAX  = 1000000
) (
    input  logic                clk50m,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] clr,
    output logic [NUM_KEYS-1:0] key_stable,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_latched
);

    localparam int W = $clog2(CNT_MAX);
    localparam logic [W-1:0] LAST = W'(CNT_MAX - 1);

    logic [NUM_KEYS-1:0] meta;
    logic [NUM_KEYS-1:0] key_sync;

    // Synchronizer idles high so reset looks like "all released".
    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            meta     <= '1;
            key_sync <= '1;
        end else begin
            meta     <= key_in;
            key_sync <= meta;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [W-1:0] cnt;
        logic         stable_q;
        logic         press_q;
        logic         rel_q;
        logic         latch_q;

        always_ff @(posedge clk50m or posedge reset) begin
            if (reset) begin
                cnt      <= '0;
                stable_q <= 1'b1;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                latch_q  <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                // Set wins over a coincident clear.
                latch_q <= press_q | (latch_q & ~clr[i]);
                if (key_sync[i] == stable_q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt      <= '0;
                    stable_q <= key_sync[i];
                    press_q  <= ~key_sync[i];
                    rel_q    <= key_sync[i];
                end else begin
                    cnt <= cnt + W'(1);
                end
            end
        end

        assign key_stable[i]  = stable_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
        assign key_latched[i] = latch_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=4, NUM_KEYS=2.
module tb_key_debounce;

    logic       clk50m = 1'b0;
    logic       reset;
    logic [1:0] key_in;
    logic [1:0] clr;
    logic [1:0] key_stable;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_latched;

    int checks = 0;
    int errors = 0;

    key_debounce #(.NUM_KEYS(2), .CNT_MAX(4)) dut (
        .clk50m      (clk50m),
        .reset       (reset),
        .key_in      (key_in),
        .clr         (clr),
        .key_stable  (key_stable),
        .key_press   (key_press),
        .key_release (key_release),
        .key_latched (key_latched)
    );

    always #5 clk50m = ~clk50m;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    // Idle n cycles with all outputs expected steady.
    task automatic idle(input int n, input logic [1:0] st, input logic [1:0] la);
        for (int k = 0; k < n; k++) begin
            step();
            chk("idle_stable", key_stable, st);
            chk("idle_press", key_press, 2'b00);
            chk("idle_release", key_release, 2'b00);
            chk("idle_latched", key_latched, la);
        end
    endtask

    initial begin
        reset  = 1'b1;
        key_in = 2'b11;
        clr    = 2'b00;
        step();
        step();
        chk("rst_stable", key_stable, 2'b11);
        chk("rst_press", key_press, 2'b00);
        chk("rst_release", key_release, 2'b00);
        chk("rst_latched", key_latched, 2'b00);
        reset = 1'b0;
        idle(6, 2'b11, 2'b00);

        // Clean press on key 0; next edge is E0
        key_in = 2'b10;
        for (int e = 0; e <= 4; e++) begin
            step();
            chk("press_wait_stable", key_stable, 2'b11);
            chk("press_wait_pulse", key_press, 2'b00);
        end
        step();
        chk("press_e5_stable", key_stable, 2'b10);
        chk("press_e5_pulse", key_press, 2'b01);
        chk("press_e5_latched", key_latched, 2'b00);
        step();
        chk("press_e6_pulse", key_press, 2'b00);
        chk("press_e6_latched", key_latched, 2'b01);

        // Release key 0
        key_in = 2'b11;
        for (int e = 0; e <= 4; e++) begin
            step();
            chk("rel_wait_stable", key_stable, 2'b10);
            chk("rel_wait_pulse", key_release, 2'b00);
        end
        step();
        chk("rel_e5_stable", key_stable, 2'b11);
        chk("rel_e5_pulse", key_release, 2'b01);
        chk("rel_e5_press", key_press, 2'b00);
        chk("rel_e5_latched", key_latched, 2'b01);
        step();
        chk("rel_e6_pulse", key_release, 2'b00);
        chk("rel_e6_latched", key_latched, 2'b01);

        clr = 2'b01;
        step();
        chk("clr_latched", key_latched, 2'b00);
        clr = 2'b00;

        // Bounce: low 3 samples, high 1, then low
        key_in = 2'b10;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("bnc_low_stable", key_stable, 2'b11);
        end
        key_in = 2'b11;
        step();
        chk("bnc_high_stable", key_stable, 2'b11);
        key_in = 2'b10;
        for (int e = 0; e <= 4; e++) begin
            step();
            chk("bnc_wait_stable", key_stable, 2'b11);
            chk("bnc_wait_pulse", key_press, 2'b00);
        end
        step();
        chk("bnc_e5_stable", key_stable, 2'b10);
        chk("bnc_e5_pulse", key_press, 2'b01);
        idle(3, 2'b10, 2'b01);

        // Release, then clear race
        key_in = 2'b11;
        for (int e = 0; e < 7; e++) step();
        chk("race_pre_stable", key_stable, 2'b11);
        clr = 2'b01;
        step();
        chk("race_pre_clr", key_latched, 2'b00);
        clr = 2'b00;
        key_in = 2'b10;
        for (int e = 0; e <= 5; e++) step();
        chk("race_e5_pulse", key_press, 2'b01);
        clr = 2'b01;
        step();
        chk("race_set_wins", key_latched, 2'b01);
        step();
        chk("race_clear", key_latched, 2'b00);
        clr = 2'b00;

        // Reset mid-count with key 0 held
        key_in = 2'b11;
        for (int e = 0; e < 7; e++) step();
        chk("mid_pre_stable", key_stable, 2'b11);
        key_in = 2'b10;
        for (int e = 0; e <= 4; e++) step();
        chk("mid_cnt3_stable", key_stable, 2'b11);
        reset = 1'b1;
        #1;
        chk("mid_rst_stable", key_stable, 2'b11);
        chk("mid_rst_press", key_press, 2'b00);
        chk("mid_rst_latched", key_latched, 2'b00);
        step();
        step();
        chk("mid_rst_hold", key_stable, 2'b11);
        reset = 1'b0;
        for (int e = 0; e <= 4; e++) begin
            step();
            chk("mid_wait_stable", key_stable, 2'b11);
            chk("mid_wait_pulse", key_press, 2'b00);
        end
        step();
        chk("mid_e5_stable", key_stable, 2'b10);
        chk("mid_e5_pulse", key_press, 2'b01);

        // Independence: key 0 then key 1 two cycles later
        key_in = 2'b11;
        for (int e = 0; e < 7; e++) step();
        chk("ind_pre_stable", key_stable, 2'b11);
        key_in = 2'b10;
        step();
        step();
        key_in = 2'b00;
        step();
        step();
        step();
        chk("ind_e4_pulse", key_press, 2'b00);
        step();
        chk("ind_e5_stable", key_stable, 2'b10);
        chk("ind_e5_pulse", key_press, 2'b01);
        step();
        chk("ind_e6_pulse", key_press, 2'b00);
        step();
        chk("ind_e7_stable", key_stable, 2'b00);
        chk("ind_e7_pulse", key_press, 2'b10);
        chk("ind_e7_release", key_release, 2'b00);
        step();
        chk("ind_e8_pulse", key_press, 2'b00);
        chk("ind_e8_latched", key_latched, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
